// File: rtl/tap_stream_player_if.sv
//------------------------------------------------------------------------------
// Module  : tap_stream_player_if
// Brief   : Tape-cache read port plus serializer start/done handshake used by
//           tap_stream_player (master) and the tape RAM / bit serializer (slave).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tap_stream_player_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] tape_addr;
  logic [7:0]        tape_data;
  logic [ADDR_W-1:0] tape_end;
  logic              byte_start;
  logic [7:0]        byte_data;
  logic              byte_gap;
  logic              byte_done;

  modport master (
    output tape_addr,
    input  tape_data,
    input  tape_end,
    output byte_start,
    output byte_data,
    output byte_gap,
    input  byte_done
  );

  modport slave (
    input  tape_addr,
    output tape_data,
    output tape_end,
    input  byte_start,
    input  byte_data,
    input  byte_gap,
    output byte_done
  );
endinterface

`default_nettype wire

// File: rtl/tap_stream_player.sv
//------------------------------------------------------------------------------
// Module  : tap_stream_player
// Brief   : Walks an Oric TAP image held in tape-cache RAM, parses each segment
//           header (sync run, 0x24 marker, 9-byte header, name) and hands bytes
//           and gap requests to an external bit serializer. Supports play/pause
//           with position hold, segment counting and sticky error reporting.
//           Optional turbo mode is compiled in with macro TAP_TURBO_EN.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tap_stream_player #(
  parameter int ADDR_W      = 16,
  parameter int RD_LAT      = 1,
  parameter int LEAD_REPEAT = 511,
  parameter int GAP_CYCLES  = 12000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                play,
  input  logic                rewind,
  tap_stream_player_if.master bus,
  output logic                busy,
  output logic                eot,
  output logic                err,
  output logic [7:0]          seg_count
`ifdef TAP_TURBO_EN
  ,
  input  logic                turbo
`endif
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PAUSE     = 4'd1,
    S_GAP_WAIT  = 4'd2,
    S_FETCH     = 4'd3,
    S_EMIT      = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_SEND_GAP  = 4'd6,
    S_ADVANCE   = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  // Header index: 0 = sync run, 1..9 = header offset 0..8 next, then name, then data.
  localparam logic [3:0]  c_HDR_SYNC = 4'd0;
  localparam logic [3:0]  c_HDR_NAME = 4'd10;
  localparam logic [3:0]  c_HDR_DATA = 4'd11;
  localparam logic [2:0]  c_RD_LAT   = 3'(RD_LAT);
  localparam logic [15:0] c_LEAD     = 16'(LEAD_REPEAT);
  localparam logic [31:0] c_GAP      = 32'(GAP_CYCLES);

  state_t            r_state;
  state_t            r_resume;
  logic [ADDR_W-1:0] r_addr;
  logic              r_byte_start;
  logic              r_byte_gap;
  logic [7:0]        r_byte_data;
  logic              r_eot;
  logic              r_err;
  logic [7:0]        r_seg_count;
  logic [15:0]       r_lead;
  logic [3:0]        r_hdr_idx;
  logic [15:0]       r_size;
  logic [15:0]       r_end;
  logic [15:0]       r_start;
  logic [31:0]       r_gap;
  logic [2:0]        r_lat;
  logic              r_gap_sent;
  logic              r_turbo;
  logic              r_play_q;

  logic              w_turbo_in;
  logic [15:0]       w_lead_lim;
  logic [31:0]       w_gap_load;
  logic              w_hold;
  logic              w_last;
  logic              w_name_end;
  logic [ADDR_W-1:0] w_next_addr;

`ifdef TAP_TURBO_EN
  assign w_turbo_in = turbo;
`else
  assign w_turbo_in = 1'b0;
`endif

  // Turbo shortens the lead-in and the inter-segment pause.
  assign w_lead_lim  = r_turbo ? 16'd15 : c_LEAD;
  assign w_gap_load  = w_turbo_in ? 32'd1 : c_GAP;
  // The first sync byte of a segment is re-emitted before the address moves on.
  assign w_hold      = (r_hdr_idx == c_HDR_SYNC) && (r_byte_data != 8'h24) &&
                       (r_lead < w_lead_lim);
  assign w_last      = (r_hdr_idx == c_HDR_DATA) && (r_size == 16'd1);
  assign w_name_end  = (r_hdr_idx == c_HDR_NAME) && (r_byte_data == 8'h00);
  assign w_next_addr = w_hold ? r_addr : r_addr + ADDR_W'(1);

  assign bus.tape_addr  = r_addr;
  assign bus.byte_start = r_byte_start;
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_gap   = r_byte_gap;
  assign eot            = r_eot;
  assign err            = r_err;
  assign seg_count      = r_seg_count;
  // Decoded straight from the state register; PAUSE counts as busy.
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);

  // Previous play level for rising-edge detection; keeps tracking across rewind
  // so a held play level does not restart the tape after a rewind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_play_q <= 1'b0;
    else          r_play_q <= play;
  end

  // Player FSM: tape walk, header parse, serializer handshake and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;      r_resume <= S_IDLE;      r_addr <= '0;
      r_byte_start <= 1'b0;   r_byte_gap <= 1'b0;      r_byte_data <= 8'h00;
      r_eot <= 1'b0;          r_err <= 1'b0;           r_seg_count <= 8'h00;
      r_lead <= 16'd0;        r_hdr_idx <= c_HDR_SYNC; r_size <= 16'd0;
      r_end <= 16'd0;         r_start <= 16'd0;        r_gap <= c_GAP;
      r_lat <= 3'd0;          r_gap_sent <= 1'b0;      r_turbo <= 1'b0;
    end else if (rewind) begin
      r_state <= S_IDLE;      r_resume <= S_IDLE;      r_addr <= '0;
      r_byte_start <= 1'b0;   r_byte_gap <= 1'b0;      r_byte_data <= 8'h00;
      r_eot <= 1'b0;          r_err <= 1'b0;           r_seg_count <= 8'h00;
      r_lead <= 16'd0;        r_hdr_idx <= c_HDR_SYNC; r_size <= 16'd0;
      r_end <= 16'd0;         r_start <= 16'd0;        r_gap <= c_GAP;
      r_lat <= 3'd0;          r_gap_sent <= 1'b0;      r_turbo <= 1'b0;
    end else begin
      r_lat <= 3'd0;
      case (r_state)
        S_IDLE: begin
          if (play && !r_play_q) begin
            r_turbo <= w_turbo_in;
            r_gap   <= w_gap_load;
            r_state <= S_GAP_WAIT;
          end
        end
        S_PAUSE: begin
          if (play) r_state <= r_resume;
        end
        S_GAP_WAIT: begin
          if (!play) begin
            r_resume <= S_GAP_WAIT;
            r_state  <= S_PAUSE;
          end else if (r_gap == 32'd0) begin
            r_state <= S_FETCH;
          end else begin
            r_gap <= r_gap - 32'd1;
          end
        end
        S_FETCH: begin
          if (r_addr == bus.tape_end) begin
            // Nothing left to read (covers an empty tape).
            r_eot   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_lat != c_RD_LAT) begin
            r_lat <= r_lat + 3'd1;
          end else if ((r_hdr_idx == c_HDR_SYNC) && (r_lead == 16'd0) &&
                       (bus.tape_data != 8'h16)) begin
            r_err   <= 1'b1;
            r_eot   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_byte_data  <= bus.tape_data;
            r_byte_start <= 1'b1;
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          r_byte_start <= 1'b0;
          r_state      <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.byte_done) begin
            if (w_name_end && !r_gap_sent && !r_turbo) begin
              r_byte_start <= 1'b1;
              r_byte_gap   <= 1'b1;
              r_state      <= S_SEND_GAP;
            end else begin
              r_state <= S_ADVANCE;
            end
          end
        end
        S_SEND_GAP: begin
          r_byte_start <= 1'b0;
          if (bus.byte_done) begin
            r_byte_gap <= 1'b0;
            r_gap_sent <= 1'b1;
            r_state    <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          r_addr <= w_next_addr;
          if (w_hold) r_lead <= r_lead + 16'd1;
          if (r_hdr_idx == c_HDR_SYNC) begin
            if (r_byte_data == 8'h24) r_hdr_idx <= 4'd1;
          end else if (r_hdr_idx < c_HDR_NAME) begin
            case (r_hdr_idx)
              4'd5:    r_end[15:8]   <= r_byte_data;
              4'd6:    r_end[7:0]    <= r_byte_data;
              4'd7:    r_start[15:8] <= r_byte_data;
              4'd8:    r_start[7:0]  <= r_byte_data;
              default: ;
            endcase
            r_hdr_idx <= r_hdr_idx + 4'd1;
          end else if (r_hdr_idx == c_HDR_NAME) begin
            if (r_byte_data == 8'h00) begin
              r_size    <= r_end - r_start + 16'd1;
              r_hdr_idx <= c_HDR_DATA;
            end
          end else begin
            r_size <= r_size - 16'd1;
            if (w_last) begin
              if (r_seg_count != 8'hFF) r_seg_count <= r_seg_count + 8'd1;
              r_lead     <= 16'd0;
              r_hdr_idx  <= c_HDR_SYNC;
              r_gap_sent <= 1'b0;
              r_gap      <= w_gap_load;
              r_turbo    <= w_turbo_in;
            end
          end
          if (w_next_addr == bus.tape_end) begin
            r_eot   <= 1'b1;
            r_state <= S_DONE;
          end else if (!play) begin
            r_resume <= w_last ? S_GAP_WAIT : S_FETCH;
            r_state  <= S_PAUSE;
          end else begin
            r_state <= w_last ? S_GAP_WAIT : S_FETCH;
          end
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tap_stream_player.sv
//------------------------------------------------------------------------------
// Module  : tb_tap_stream_player
// Brief   : Directed self-checking bench for tap_stream_player with a latency-2
//           tape RAM model and a fixed-delay serializer that logs every item.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tap_stream_player;
  localparam int ADDR_W      = 16;
  localparam int RD_LAT      = 2;
  localparam int LEAD_REPEAT = 4;
  localparam int GAP_CYCLES  = 10;

  typedef struct {
    logic        gap;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } item_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       play = 1'b0;
  logic       rewind = 1'b0;
`ifdef TAP_TURBO_EN
  logic       turbo = 1'b0;
`endif
  logic       busy, eot, err;
  logic [7:0] seg_count;

  tap_stream_player_if #(.ADDR_W(ADDR_W)) bus ();

  tap_stream_player #(
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LEAD_REPEAT(LEAD_REPEAT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .rewind(rewind), .bus(bus),
    .busy(busy), .eot(eot), .err(err), .seg_count(seg_count)
`ifdef TAP_TURBO_EN
    , .turbo(turbo)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tape RAM: data appears RD_LAT clock edges after the address changes.
  logic [7:0] mem [0:255];
  logic [7:0] r_p1, r_p2;
  always @(posedge clk) begin
    r_p1 <= mem[bus.tape_addr[7:0]];
    r_p2 <= r_p1;
  end
  assign bus.tape_data = r_p2;

  // Serializer: logs each started item, answers with byte_done four edges later.
  item_t      log_q[$];
  int         cyc = 0;
  int         n_overlap = 0;
  logic       ser_pend = 1'b0;
  logic [2:0] ser_cnt = 3'd0;

  function automatic item_t mk_item(logic g, logic [15:0] a, logic [7:0] d, int c);
    item_t it;
    it.gap = g; it.addr = a; it.data = d; it.cyc = c;
    return it;
  endfunction

  function automatic logic [31:0] code(item_t it);
    return {7'd0, it.gap, it.addr, it.data};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.byte_done <= 1'b0;
    if (bus.byte_start) begin
      if (ser_pend) n_overlap <= n_overlap + 1;
      log_q.push_back(mk_item(bus.byte_gap, bus.tape_addr, bus.byte_data, cyc));
      ser_pend <= 1'b1;
      ser_cnt  <= 3'd3;
    end else if (ser_pend) begin
      if (ser_cnt == 3'd0) begin
        bus.byte_done <= 1'b1;
        ser_pend      <= 1'b0;
      end else begin
        ser_cnt <= ser_cnt - 3'd1;
      end
    end
  end

  // Segment A at 0..17 (end 0x0502, start 0x0500, name "A"), segment B at 18..31.
  logic [7:0]  seg_a [0:17];
  logic [7:0]  seg_b [0:13];
  logic [31:0] exp_q[$];

  task automatic ex(input logic g, input int a, input logic [7:0] d);
    exp_q.push_back({7'd0, g, 16'(a), d});
  endtask

  task automatic exp_seg_a(input int lead, input logic gap_on);
    for (int i = 0; i <= lead; i++) ex(1'b0, 0, 8'h16);
    for (int a = 1; a <= 14; a++) ex(1'b0, a, seg_a[a]);
    if (gap_on) ex(1'b1, 14, 8'h00);
    for (int a = 15; a <= 17; a++) ex(1'b0, a, seg_a[a]);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_item%0d", tag, i), code(log_q[i]), exp_q[i]);
  endtask

  task automatic restart(input logic [15:0] te);
    play = 1'b0;
    repeat (12) @(posedge clk);
    #1 rewind = 1'b1;
    @(posedge clk);
    #1 rewind = 1'b0;
    log_q.delete();
    exp_q.delete();
    bus.tape_end = te;
    @(posedge clk);
    #1 play = 1'b1;
  endtask

  task automatic wait_eot(input string tag, input int max);
    for (int i = 0; i < max && eot !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, eot, 1'b1);
  endtask

  task automatic wait_items(input string tag, input int n, input int max);
    for (int i = 0; i < max && log_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, (log_q.size() >= n), 1'b1);
  endtask

  initial begin
    int bad;
    seg_a = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'hC7, 8'h05,
              8'h02, 8'h05, 8'h00, 8'h00, 8'h41, 8'h00, 8'hD1, 8'hD2, 8'hD3};
    seg_b = '{8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'h00, 8'h06, 8'h00, 8'h06,
              8'h00, 8'h00, 8'h42, 8'h00, 8'hE1};
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    for (int a = 0; a < 18; a++) mem[a] = seg_a[a];
    for (int a = 0; a < 14; a++) mem[18 + a] = seg_b[a];
    bus.tape_end = 16'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_addr", bus.tape_addr, 0);
    check("rst_start", bus.byte_start, 0);
    check("rst_data", bus.byte_data, 0);
    check("rst_gap", bus.byte_gap, 0);
    check("rst_busy", busy, 0);
    check("rst_eot", eot, 0);
    check("rst_err", err, 0);
    check("rst_segcnt", seg_count, 0);

    // One segment; address 18 holds a lone trailing sync byte before tape_end=19
    restart(16'd19);
    wait_eot("one_eot", 3000);
    exp_seg_a(LEAD_REPEAT, 1'b1);
    for (int i = 0; i <= LEAD_REPEAT; i++) ex(1'b0, 18, 8'h16);
    compare_log("one");
    check("one_segcnt", seg_count, 1);
    check("one_err", err, 0);
    check("one_busy", busy, 0);
    if (log_q.size() > 23)
      check("one_gap_delta", log_q[23].cyc - log_q[22].cyc, 21);

    // Two back-to-back segments
    restart(16'd32);
    wait_eot("two_eot", 4000);
    exp_seg_a(LEAD_REPEAT, 1'b1);
    for (int i = 0; i <= LEAD_REPEAT; i++) ex(1'b0, 18, 8'h16);
    for (int a = 19; a <= 30; a++) ex(1'b0, a, seg_b[a - 18]);
    ex(1'b1, 30, 8'h00);
    ex(1'b0, 31, 8'hE1);
    compare_log("two");
    check("two_segcnt", seg_count, 2);
    check("two_err", err, 0);
    if (log_q.size() > 23)
      check("two_gap_delta", log_q[23].cyc - log_q[22].cyc, 21);

    // Bad first byte
    mem[0] = 8'h55;
    restart(16'd19);
    wait_eot("bad_eot", 500);
    check("bad_err", err, 1);
    check("bad_items", log_q.size(), 0);
    check("bad_busy", busy, 0);
    mem[0] = 8'h16;

    // Empty tape
    restart(16'd0);
    wait_eot("empty_eot", 500);
    check("empty_items", log_q.size(), 0);
    check("empty_err", err, 0);

    // Pause mid-header after the byte at address 6
    restart(16'd19);
    wait_items("pause_reach", 11, 2000);
    play = 1'b0;
    check("pause_item_addr", log_q[10].addr, 6);
    repeat (20) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.tape_addr !== 16'd7) bad++;
    end
    check("pause_hold", bad, 0);
    check("pause_items", log_q.size(), 11);
    check("pause_busy", busy, 1);
    play = 1'b1;
    wait_items("resume_reach", 12, 200);
    if (log_q.size() > 11) check("resume_item", code(log_q[11]), {7'd0, 1'b0, 16'd7, 8'hC7});
    wait_eot("resume_eot", 3000);
    check("resume_segcnt", seg_count, 1);

    // Rewind while a byte is in flight
    restart(16'd19);
    wait_items("rew_reach", 8, 2000);
    rewind = 1'b1;
    @(posedge clk);
    #1 rewind = 1'b0;
    check("rew_addr", bus.tape_addr, 0);
    check("rew_busy", busy, 0);
    check("rew_eot", eot, 0);
    repeat (10) @(posedge clk);
    #1;
    check("rew_late_busy", busy, 0);
    check("rew_late_items", log_q.size(), 8);

`ifdef TAP_TURBO_EN
    // Turbo: 16-fold lead-in, no gap item, one-cycle inter-segment pause
    turbo = 1'b1;
    restart(16'd19);
    wait_eot("turbo_eot", 3000);
    exp_seg_a(15, 1'b0);
    for (int i = 0; i <= 15; i++) ex(1'b0, 18, 8'h16);
    compare_log("turbo");
    if (log_q.size() > 33)
      check("turbo_gap_delta", log_q[33].cyc - log_q[32].cyc, 12);
    turbo = 1'b0;
`endif

    // Asynchronous reset while a byte is being started
    restart(16'd19);
    wait_items("areset_reach", 8, 2000);
    for (int i = 0; i < 50 && bus.byte_start !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check("areset_in_emit", bus.byte_start, 1);
    #2 reset_n = 1'b0;
    play = 1'b0;
    #1;
    check("areset_addr", bus.tape_addr, 0);
    check("areset_start", bus.byte_start, 0);
    check("areset_data", bus.byte_data, 0);
    check("areset_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    check("no_overlap", n_overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
